regfile_write_ctrl: RTL and testbench

Write-port controller for the 32x32 register file: the single owner of its write_signal, Write_reg and Write_data inputs. After reset it scrubs every register to zero, then arbitrates the one write port between core writeback (priority) and a valid/ready debug write port. An anti-starvation counter guarantees debug forward progress, and writes to x0 are suppressed.

---
 rtl/regfile_write_ctrl.sv | 156 +++++++++++++++
 tb/tb_regfile_write_ctrl.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_write_ctrl.sv
// regfile_write_ctrl: single owner of the 32x32 register file write port.
// After reset it optionally scrubs every register to zero. It then arbitrates
// the write port between core writeback (priority) and a valid/ready debug
// port. A starvation counter forces a one-cycle debug grant, and writes to
// x0 are suppressed.
// Build option: define RF_SCRUB_EN to include the post-reset scrub phase.
// Without it, reset goes straight to normal operation.

module regfile_write_ctrl #(
  parameter int DATA_W       = 32,
  parameter int ADDR_W       = 5,
  parameter int NUM_REGS     = 32,
  parameter int STARVE_LIMIT = 8,
  parameter int CNT_W        = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wb_en,
  input  logic [ADDR_W-1:0] wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  output logic              core_stall,
  input  logic              dbg_valid,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_data,
  output logic              dbg_ready,
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic              init_done
);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_FORCE = 2'd1,
    ST_SCRUB = 2'd2
  } state_t;

`ifdef RF_SCRUB_EN
  localparam state_t RESET_STATE = ST_SCRUB;
  logic [ADDR_W-1:0] r_scrubCnt;
`else
  localparam state_t RESET_STATE = ST_RUN;
`endif

  state_t            r_state;
  logic [CNT_W-1:0]  r_starveCnt;

  logic              w_selValid;
  logic [ADDR_W-1:0] w_selAddr;
  logic [DATA_W-1:0] w_selData;
  logic              w_dbgBlocked;
  logic              w_forceNext;
  logic              w_starveSat;
  logic [CNT_W:0]    w_starveInc;

  // Debug is blocked only in RUN while the core holds the port.
  assign w_dbgBlocked = (r_state == ST_RUN) && dbg_valid && wb_en;
  assign w_starveInc  = {1'b0, r_starveCnt} + {{CNT_W{1'b0}}, 1'b1};
  assign w_starveSat  = &r_starveCnt;
  // The blocked cycle that brings the count to the limit schedules FORCE.
  assign w_forceNext  = (STARVE_LIMIT != 0) && w_dbgBlocked &&
                        (w_starveInc >= (CNT_W+1)'(STARVE_LIMIT));

  // Port muxing and handshake outputs; everything is held inert while reset is low.
  always_comb begin
    w_selValid = 1'b0;
    w_selAddr  = '0;
    w_selData  = '0;
    rf_we      = 1'b0;
    rf_waddr   = '0;
    rf_wdata   = '0;
    core_stall = 1'b1;
    dbg_ready  = 1'b0;
    init_done  = 1'b0;
    if (rst) begin
      case (r_state)
`ifdef RF_SCRUB_EN
        ST_SCRUB: begin
          rf_we    = 1'b1;
          rf_waddr = r_scrubCnt;
        end
`endif
        ST_FORCE: begin
          init_done = 1'b1;
          dbg_ready = 1'b1;
          if (dbg_valid) begin
            w_selValid = 1'b1;
            w_selAddr  = dbg_addr;
            w_selData  = dbg_data;
          end
        end
        default: begin
          init_done  = 1'b1;
          core_stall = 1'b0;
          if (wb_en) begin
            w_selValid = 1'b1;
            w_selAddr  = wb_addr;
            w_selData  = wb_data;
          end else begin
            dbg_ready = 1'b1;
            if (dbg_valid) begin
              w_selValid = 1'b1;
              w_selAddr  = dbg_addr;
              w_selData  = dbg_data;
            end
          end
        end
      endcase
      if (w_selValid && (w_selAddr != '0)) begin
        rf_we    = 1'b1;
        rf_waddr = w_selAddr;
        rf_wdata = w_selData;
      end
    end
  end

  // State machine: scrub sweep, normal arbitration, and the one-cycle forced debug grant.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= RESET_STATE;
      r_starveCnt <= '0;
`ifdef RF_SCRUB_EN
      r_scrubCnt  <= '0;
`endif
    end else begin
      case (r_state)
`ifdef RF_SCRUB_EN
        ST_SCRUB: begin
          r_scrubCnt <= r_scrubCnt + 1'b1;
          if (r_scrubCnt == ADDR_W'(NUM_REGS - 1)) begin
            r_state <= ST_RUN;
          end
        end
`endif
        ST_FORCE: begin
          r_starveCnt <= '0;
          r_state     <= ST_RUN;
        end
        default: begin
          r_state <= ST_RUN;
          if (w_forceNext) begin
            r_starveCnt <= w_starveInc[CNT_W-1:0];
            r_state     <= ST_FORCE;
          end else if (w_dbgBlocked) begin
            if (!w_starveSat) begin
              r_starveCnt <= w_starveInc[CNT_W-1:0];
            end
          end else begin
            r_starveCnt <= '0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_write_ctrl.sv
// Testbench for regfile_write_ctrl: random and directed stimulus compared
// against a behavioural model of the arbitration rules and of register contents.

module tb_regfile_write_ctrl;

  localparam int DATA_W       = 32;
  localparam int ADDR_W       = 5;
  localparam int NUM_REGS     = 32;
  localparam int STARVE_LIMIT = 8;
`ifdef RF_SCRUB_EN
  localparam bit HAS_SCRUB = 1'b1;
`else
  localparam bit HAS_SCRUB = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              wb_en = 1'b0;
  logic [ADDR_W-1:0] wb_addr = '0;
  logic [DATA_W-1:0] wb_data = '0;
  logic              dbg_valid = 1'b0;
  logic [ADDR_W-1:0] dbg_addr = '0;
  logic [DATA_W-1:0] dbg_data = '0;
  logic              core_stall, dbg_ready, rf_we, init_done;
  logic [ADDR_W-1:0] rf_waddr;
  logic [DATA_W-1:0] rf_wdata;

  int errors = 0;
  int checks = 0;

  // Model state: cycles since reset release, consecutive blocked debug cycles,
  // pending forced grant, and the expected register file contents.
  int          mCyc = 0;
  int          mBlocked = 0;
  bit          mForce = 1'b0;
  logic [31:0] mMem   [NUM_REGS];
  bit          mKnown [NUM_REGS];
  logic [31:0] tbRf   [NUM_REGS];

  logic        eWe, eStall, eReady, eDone, eCare;
  logic [4:0]  eAddr;
  logic [31:0] eData;

  regfile_write_ctrl #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_REGS(NUM_REGS),
    .STARVE_LIMIT(STARVE_LIMIT), .CNT_W(4)
  ) dut (
    .clk(clk), .rst(rst),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .core_stall(core_stall),
    .dbg_valid(dbg_valid), .dbg_addr(dbg_addr), .dbg_data(dbg_data),
    .dbg_ready(dbg_ready),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .init_done(init_done)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  // Register file stand-in that captures whatever the DUT commits.
  always @(posedge clk) begin
    if (rf_we) tbRf[rf_waddr] <= rf_wdata;
  end

  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic resetModel();
    mCyc = 0;
    mBlocked = 0;
    mForce = 1'b0;
  endtask

  // Expected outputs for the current inputs, derived from the arbitration rules.
  task automatic computeExpect();
    logic        useWb, useDbg;
    logic [4:0]  a;
    logic [31:0] d;
    eWe = 0; eAddr = 0; eData = 0; eStall = 1; eReady = 0; eDone = 0; eCare = 1;
    useWb = 0; useDbg = 0; a = 0; d = 0;
    if (rst) begin
      if (HAS_SCRUB && mCyc < NUM_REGS) begin
        eWe = 1; eAddr = 5'(mCyc);
      end else begin
        eDone = 1;
        if (mForce) begin
          eStall = 1; eReady = 1; useDbg = dbg_valid;
        end else begin
          eStall = 0; eReady = !wb_en; useWb = wb_en; useDbg = !wb_en && dbg_valid;
        end
        if (useWb) begin a = wb_addr; d = wb_data; end
        else if (useDbg) begin a = dbg_addr; d = dbg_data; end
        if (useWb || useDbg) begin
          eWe = (a != 0); eAddr = a; eData = d; eCare = (a != 0);
        end
      end
    end
  endtask

  task automatic checkOutput();
    checkVal("rf_we", 32'(rf_we), 32'(eWe));
    checkVal("core_stall", 32'(core_stall), 32'(eStall));
    checkVal("dbg_ready", 32'(dbg_ready), 32'(eReady));
    checkVal("init_done", 32'(init_done), 32'(eDone));
    if (eCare) begin
      checkVal("rf_waddr", 32'(rf_waddr), 32'(eAddr));
      checkVal("rf_wdata", rf_wdata, eData);
    end
  endtask

  // Advance the model by one clock edge with the inputs currently applied.
  task automatic clockModel();
    if (!rst) begin
      resetModel();
    end else begin
      if (eWe) begin mMem[eAddr] = eData; mKnown[eAddr] = 1'b1; end
      if (HAS_SCRUB && mCyc < NUM_REGS) begin
        mCyc++;
      end else if (mForce) begin
        mForce = 1'b0; mBlocked = 0;
      end else if (dbg_valid && wb_en) begin
        mBlocked++;
        if (STARVE_LIMIT != 0 && mBlocked >= STARVE_LIMIT) mForce = 1'b1;
      end else begin
        mBlocked = 0;
      end
    end
  endtask

  task automatic applyStimulus(input logic r, input logic we, input logic [4:0] wa, input logic [31:0] wd,
                               input logic dv, input logic [4:0] da, input logic [31:0] dd);
    @(negedge clk);
    rst = r; wb_en = we; wb_addr = wa; wb_data = wd;
    dbg_valid = dv; dbg_addr = da; dbg_data = dd;
    #1;
    computeExpect();
    checkOutput();
  endtask

  task automatic step(input logic r, input logic we, input logic [4:0] wa, input logic [31:0] wd,
                      input logic dv, input logic [4:0] da, input logic [31:0] dd);
    applyStimulus(r, we, wa, wd, dv, da, dd);
    clockModel();
  endtask

  task automatic randomStep(input logic r);
    step(r, 1'($urandom_range(0, 9) < 6), 5'($urandom_range(0, 31)), $urandom,
         1'($urandom_range(0, 9) < 6), 5'($urandom_range(0, 31)), $urandom);
  endtask

  // Assert reset between clock edges and confirm outputs drop without a clock.
  task automatic asyncResetCheck();
    #2;
    rst = 1'b0;
    #1;
    resetModel();
    computeExpect();
    checkOutput();
  endtask

  // Drive a blocked debug request until the model schedules a forced grant.
  task automatic driveToForce(input logic [4:0] da, input logic [31:0] dd);
    int n = 0;
    while (!mForce && n < 20) begin
      step(1, 1, 5'($urandom_range(1, 31)), $urandom, 1, da, dd);
      n++;
    end
    if (!mForce) begin
      checks++;
      errors++;
      $display("[TB] FAIL force_timeout observed=no_force expected=force_within_20");
    end
  endtask

  initial begin
    for (int i = 0; i < NUM_REGS; i++) mKnown[i] = 1'b0;
    #2 rst = 1'b0;

    // Reset values, including across clock edges with active inputs.
    for (int i = 0; i < 3; i++) randomStep(0);

    // Release; scrub sweep (when built) followed by normal operation.
    for (int i = 0; i < NUM_REGS + 4; i++) randomStep(1);
    step(1, 0, 0, 0, 0, 0, 0);

    // Core wins over a simultaneous debug request, debug lands next cycle.
    step(1, 1, 5, 32'hDEADBEEF, 1, 6, 32'h12345678);
    step(1, 0, 0, 0, 1, 6, 32'h12345678);
    step(1, 0, 0, 0, 0, 0, 0);

    // Starvation: held core traffic, debug forced through after the limit.
    for (int i = 0; i < STARVE_LIMIT + 3; i++)
      step(1, 1, 5'(8 + i), 32'(i) * 32'h01010101, 1, 7, 32'hA5A5A5A5);
    step(1, 0, 0, 0, 0, 0, 0);

    // FORCE cycle with debug dropped: no write at all.
    driveToForce(9, 32'h0BADF00D);
    step(1, 1, 3, 32'h33333333, 0, 9, 32'h0BADF00D);

    // x0 writes suppressed for both requesters; debug still accepted.
    step(1, 1, 0, 32'h00001234, 0, 0, 0);
    step(1, 0, 0, 0, 1, 0, 32'hFFFFFFFF);
    step(1, 1, 0, 32'h5555, 1, 0, 32'h6666);

    // Randomized traffic.
    for (int i = 0; i < 300; i++) randomStep(1);

    // Reset asserted mid-FORCE.
    driveToForce(11, 32'hCAFEF00D);
    applyStimulus(1, 1, 12, 32'h1, 1, 11, 32'hCAFEF00D);
    asyncResetCheck();
    step(0, 1, 12, 32'h1, 1, 11, 32'h2);

    // Release and reset again mid-scrub (address 10 when scrubbing is built).
    for (int i = 0; i < 10; i++) randomStep(1);
    applyStimulus(1, 1, 13, 32'h77, 0, 0, 0);
    asyncResetCheck();
    step(0, 0, 0, 0, 0, 0, 0);

    // Scrub restarts from address 0, then normal operation resumes.
    for (int i = 0; i < NUM_REGS + 6; i++) randomStep(1);
    step(1, 1, 20, 32'hFEEDFACE, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0);

    // Register contents captured from the port must match the model.
    @(negedge clk);
    for (int i = 0; i < NUM_REGS; i++) begin
      if (mKnown[i]) checkVal($sformatf("reg%0d", i), tbRf[i], mMem[i]);
    end
    if (HAS_SCRUB) checkVal("reg0_zero", tbRf[0], 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
